// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width, control codes, clock/test patterns, mode encodings.
package tmds_pkg;
  localparam int TMDS_SYMW = 10;

  localparam logic [TMDS_SYMW-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_SYMW-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_SYMW-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_SYMW-1:0] CTRL_11 = 10'b1010101011;

  localparam logic [TMDS_SYMW-1:0] CLK_PAT  = 10'b1111100000;
  localparam logic [TMDS_SYMW-1:0] TEST_PAT = 10'b0101010101;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_IDLE   = 2'd1,
    MODE_TEST   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;
endpackage

// File: rtl/tmds_shift_chan.sv
// One serial lane: SYMW-bit right shift register with parallel load and an inverting output flop.
module tmds_shift_chan
  import tmds_pkg::*;
#(
  parameter int              SYMW    = TMDS_SYMW,
  parameter logic [SYMW-1:0] RST_VAL = '0,
  parameter logic            INV     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SYMW-1:0] load_val,
  output logic            q
);
  logic [SYMW-1:0] shreg;

  // The bit leaving on a load cycle is the old symbol's MSB; the new symbol starts next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= RST_VAL;
      q     <= INV;
    end else begin
      q     <= shreg[0] ^ INV;
      shreg <= load ? load_val : (shreg >> 1);
    end
  end
endmodule

// File: rtl/tmds_serializer.sv
// Multi-channel TMDS serialiser: free-running bit counter, symbol handshake, underrun flag,
// CHANNELS data lanes plus a clock lane locked to the same symbol boundaries.
module tmds_serializer #(
  parameter int                  CHANNELS = 3,
  parameter int                  SYMW     = 10,
  parameter logic [CHANNELS:0]   INV_MASK = '0,
  parameter logic [SYMW-1:0]     IDLE_SYM = tmds_pkg::CTRL_00,
  parameter logic [SYMW-1:0]     CLK_PAT  = tmds_pkg::CLK_PAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic [CHANNELS*SYMW-1:0] sym_data,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic                     underrun_clr,
  output logic                     underrun,
  output logic [CHANNELS-1:0]      tmds,
  output logic                     tmds_clk
);
  import tmds_pkg::*;

  localparam int              CW       = $clog2(SYMW);
  localparam logic [CW-1:0]   LAST     = CW'(SYMW - 1);
  localparam logic [SYMW-1:0] TEST_SYM = SYMW'({(SYMW + 1) / 2{2'b01}});

  logic [CW-1:0]                    bit_cnt;
  logic                             load;
  mode_e                            mode_q;
  logic [CHANNELS-1:0][SYMW-1:0]    nxt;

  assign mode_q    = mode_e'(mode);
  assign load      = (bit_cnt == LAST);
  assign sym_ready = load && (mode_q == MODE_NORMAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_cnt <= '0;
    else        bit_cnt <= load ? '0 : bit_cnt + CW'(1);
  end

  // Set has priority over clear so a new underrun is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        underrun <= 1'b0;
    else if (sym_ready && !sym_valid)  underrun <= 1'b1;
    else if (underrun_clr)             underrun <= 1'b0;
  end

  always_comb begin
    nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_q)
        MODE_NORMAL: nxt[i] = sym_valid ? sym_data[i*SYMW +: SYMW] : IDLE_SYM;
        MODE_TEST:   nxt[i] = TEST_SYM;
        default:     nxt[i] = IDLE_SYM;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    tmds_shift_chan #(
      .SYMW    (SYMW),
      .RST_VAL (IDLE_SYM),
      .INV     (INV_MASK[g])
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (nxt[g]),
      .q        (tmds[g])
    );
  end

  tmds_shift_chan #(
    .SYMW    (SYMW),
    .RST_VAL (CLK_PAT),
    .INV     (INV_MASK[CHANNELS])
  ) u_clk_chan (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CLK_PAT),
    .q        (tmds_clk)
  );
endmodule
